// File: rtl/memory_arbiter.sv
// memory_arbiter: shares a single RAM port between the instruction-fetch requester
// and the data-memory requester. Data requests win by default; a streak guard forces
// an instruction grant after MAX_DSTREAK back-to-back data grants while a fetch waits.
// Each transaction is latched on grant and ends with a one-cycle wait-low completion.
// Optional build macro: MEMORY_ARBITER_PERF_EN adds grant / blocking counters.
module memory_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MAX_DSTREAK = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [DATA_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dwait,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic              ramready
`ifdef MEMORY_ARBITER_PERF_EN
    ,
    output logic [31:0]       perf_igrants,
    output logic [31:0]       perf_dgrants,
    output logic [31:0]       perf_iblocked
`endif
);

    typedef enum logic [1:0] {IDLE, DACC, IACC, DONE} state_t;

    // Streak counter must hold 0..MAX_DSTREAK; keep at least one bit when the guard is off.
    localparam int STREAK_W = (MAX_DSTREAK < 1) ? 1 : $clog2(MAX_DSTREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DSTREAK);

    state_t              state;
    logic [STREAK_W-1:0] streak;

    logic starve;
    logic grant_d;
    logic grant_i;

    // Grant decision is only meaningful in IDLE; the starvation guard overrides data priority.
    assign starve  = (MAX_DSTREAK != 0) && (streak == STREAK_MAX) && iREN;
    assign grant_d = (state == IDLE) && (dREN || dWEN) && !starve;
    assign grant_i = (state == IDLE) && iREN && !grant_d;

    // Arbitration FSM: latch the winner, hold RAM strobes until ramready, then pulse the owner's wait.
    always_ff @(posedge CLK) begin
        if (RST) begin
            // NOTE: every register, including the held load data, has a defined reset value so
            // an abort mid-transaction leaves no stale strobe or completion behind.
            state    <= IDLE;
            streak   <= '0;
            iwait    <= 1'b1;
            dwait    <= 1'b1;
            iload    <= '0;
            dload    <= '0;
            ramREN   <= 1'b0;
            ramWEN   <= 1'b0;
            ramaddr  <= '0;
            ramstore <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state    <= DACC;
                        ramaddr  <= daddr;
                        ramstore <= dstore;
                        // A simultaneous read and write request resolves to the write.
                        ramWEN   <= dWEN;
                        ramREN   <= !dWEN;
                        if (!iREN) begin
                            streak <= '0;
                        end else if (streak != STREAK_MAX) begin
                            streak <= streak + STREAK_W'(1);
                        end
                    end else if (grant_i) begin
                        state    <= IACC;
                        ramaddr  <= iaddr;
                        ramstore <= '0;
                        ramREN   <= 1'b1;
                        ramWEN   <= 1'b0;
                        streak   <= '0;
                    end else begin
                        // No request at all implies iREN is low, which clears the streak.
                        streak <= '0;
                    end
                end
                DACC: begin
                    if (ramready) begin
                        state  <= DONE;
                        ramREN <= 1'b0;
                        ramWEN <= 1'b0;
                        dwait  <= 1'b0;
                        // A write leaves the previous read data in place.
                        if (ramREN) begin
                            dload <= ramload;
                        end
                    end
                end
                IACC: begin
                    if (ramready) begin
                        state  <= DONE;
                        ramREN <= 1'b0;
                        ramWEN <= 1'b0;
                        iwait  <= 1'b0;
                        iload  <= ramload;
                    end
                end
                DONE: begin
                    // Requests are ignored here so a request still held high is not re-issued.
                    state <= IDLE;
                    iwait <= 1'b1;
                    dwait <= 1'b1;
                end
            endcase
        end
    end

`ifdef MEMORY_ARBITER_PERF_EN
    // Performance counters: grants per requester and fetch cycles lost to data traffic.
    always_ff @(posedge CLK) begin
        if (RST) begin
            perf_igrants  <= '0;
            perf_dgrants  <= '0;
            perf_iblocked <= '0;
        end else begin
            if (grant_i) begin
                perf_igrants <= perf_igrants + 32'd1;
            end
            if (grant_d) begin
                perf_dgrants <= perf_dgrants + 32'd1;
            end
            if (iREN && (grant_d || (state == DACC))) begin
                perf_iblocked <= perf_iblocked + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed stimulus with a bench-side RAM responder and scoreboards
// for RAM accesses (grant order, latched strobes) and requester completions.
module tb_memory_arbiter;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore;
    logic        iwait, dwait;
    logic [31:0] iload, dload;
    logic        ramREN, ramWEN;
    logic [31:0] ramaddr, ramstore;
    logic [31:0] ramload = 32'h0;
    logic        ramready = 1'b0;
`ifdef MEMORY_ARBITER_PERF_EN
    logic [31:0] perf_igrants, perf_dgrants, perf_iblocked;
`endif

    memory_arbiter dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramready(ramready)
`ifdef MEMORY_ARBITER_PERF_EN
        , .perf_igrants(perf_igrants), .perf_dgrants(perf_dgrants),
        .perf_iblocked(perf_iblocked)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        data;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] store;
    } ram_op_t;

    ram_op_t     ram_q[$];
    logic [31:0] iq[$];
    logic [31:0] dq[$];
    ram_op_t     cur;
    logic        cur_valid = 1'b0;
    logic [31:0] dload_exp = 32'h0;
    logic        iren_last_edge = 1'b0;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int i_done = 0;
    int d_done = 0;
    int i_pulse_cyc = 0;
    int d_pulse_cyc = 0;
    int lat = 1;
    int acc_cnt = 0;
    int blk_meas = 0;
    logic stray = 1'b0;

    function automatic logic [31:0] ram_val(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h0F0F_3C3C;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic exp_fetch(input logic [31:0] a);
        ram_q.push_back('{data: 1'b0, wen: 1'b0, addr: a, store: 32'h0});
        iq.push_back(ram_val(a));
    endtask

    task automatic exp_dread(input logic [31:0] a);
        ram_q.push_back('{data: 1'b1, wen: 1'b0, addr: a, store: 32'h0});
        dload_exp = ram_val(a);
        dq.push_back(dload_exp);
    endtask

    task automatic exp_dwrite(input logic [31:0] a, input logic [31:0] s);
        ram_q.push_back('{data: 1'b1, wen: 1'b1, addr: a, store: s});
        dq.push_back(dload_exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Wait (bounded) until the completion counters reach the targets, then check them exactly.
    task automatic wait_done(input int ti, input int td, input string tag);
        int budget;
        budget = 300;
        while ((i_done < ti || d_done < td) && budget > 0) begin
            @(negedge CLK);
            #1;
            budget--;
        end
        check({tag, "_icount"}, 32'(i_done), 32'(ti));
        check({tag, "_dcount"}, 32'(d_done), 32'(td));
    endtask

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        iren_last_edge <= iREN;
    end

    // RAM responder: checks each access against the expected grant order and
    // keeps checking the strobes every cycle until it signals ready.
    always @(negedge CLK) begin
        if (ramREN || ramWEN) begin
            if (acc_cnt == 0) begin
                if (ram_q.size() == 0) begin
                    check("ram_spurious", {30'b0, ramREN, ramWEN}, 32'd0);
                    cur_valid = 1'b0;
                end else begin
                    cur = ram_q.pop_front();
                    cur_valid = 1'b1;
                    if (cur.data && iren_last_edge) blk_meas++;
                end
            end
            if (cur_valid) begin
                check("ram_wen", 32'(ramWEN), 32'(cur.wen));
                check("ram_ren", 32'(ramREN), 32'(!cur.wen));
                check("ram_addr", ramaddr, cur.addr);
                if (cur.wen) check("ram_store", ramstore, cur.store);
                if (cur.data && iREN) blk_meas++;
            end
            ramready = (acc_cnt >= lat);
            ramload  = ramready ? ram_val(ramaddr) : 32'hBAD0_BAD0;
            acc_cnt++;
        end else begin
            acc_cnt  = 0;
            ramready = stray;
            ramload  = 32'hBAD0_BAD0;
        end
    end

    // Completion monitor: each wait-low cycle pops one expected load value.
    always @(negedge CLK) begin
        if (!RST) begin
            if (iwait === 1'b0) begin
                if (iq.size() == 0) check("iwait_spurious", 32'(iwait), 32'd1);
                else check("iload", iload, iq.pop_front());
                i_done++;
                i_pulse_cyc = cyc;
            end
            if (dwait === 1'b0) begin
                if (dq.size() == 0) check("dwait_spurious", 32'(dwait), 32'd1);
                else check("dload", dload, dq.pop_front());
                d_done++;
                d_pulse_cyc = cyc;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cycles=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = 32'h0; daddr = 32'h0; dstore = 32'h0;
        RST = 1'b1;
        tick(3);

        // Reset values
        check("rst_iwait", 32'(iwait), 32'd1);
        check("rst_dwait", 32'(dwait), 32'd1);
        check("rst_iload", iload, 32'h0);
        check("rst_dload", dload, 32'h0);
        check("rst_ramren", 32'(ramREN), 32'd0);
        check("rst_ramwen", 32'(ramWEN), 32'd0);
        check("rst_ramaddr", ramaddr, 32'h0);
        check("rst_ramstore", ramstore, 32'h0);
        RST = 1'b0;
        tick(2);

        // Single fetch, ready on the second IACC cycle
        iaddr = 32'h40; iREN = 1'b1;
        exp_fetch(32'h40);
        tick(1);
        check("t1_ren_c1", 32'(ramREN), 32'd1);
        check("t1_addr_c1", ramaddr, 32'h40);
        tick(1);
        check("t1_ren_c2", 32'(ramREN), 32'd1);
        check("t1_addr_c2", ramaddr, 32'h40);
        tick(1);
        check("t1_ren_done", 32'(ramREN), 32'd0);
        check("t1_iwait", 32'(iwait), 32'd0);
        check("t1_dwait", 32'(dwait), 32'd1);
        check("t1_iload", iload, ram_val(32'h40));
        iREN = 1'b0;
        tick(1);
        check("t1_iwait_after", 32'(iwait), 32'd1);
        tick(3);

        // Data and fetch requested together: data first, then fetch
        daddr = 32'h100; dREN = 1'b1;
        iaddr = 32'h180; iREN = 1'b1;
        exp_dread(32'h100);
        exp_fetch(32'h180);
        wait_done(1, 1, "t2_d");
        dREN = 1'b0;
        wait_done(2, 1, "t2_i");
        iREN = 1'b0;
        check("t2_gap_ge3", 32'((i_pulse_cyc - d_pulse_cyc) >= 3), 32'd1);
        tick(3);

        // Both held high: grant order D,D,D,D,I,D,D,D,D,I
        daddr = 32'h200; dREN = 1'b1;
        iaddr = 32'h280; iREN = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (k % 5 == 4) exp_fetch(32'h280);
            else exp_dread(32'h200);
        end
        wait_done(4, 9, "t3");
        dREN = 1'b0; iREN = 1'b0;
        tick(3);

        // Write with the address changed mid-access; dload keeps the last read value
        daddr = 32'h80; dstore = 32'hDEAD_BEEF; dWEN = 1'b1;
        exp_dwrite(32'h80, 32'hDEAD_BEEF);
        tick(1);
        daddr = 32'h84; dstore = 32'h1111_2222;
        check("t4_wen", 32'(ramWEN), 32'd1);
        check("t4_addr", ramaddr, 32'h80);
        wait_done(4, 10, "t4");
        dWEN = 1'b0;
        check("t4_dload", dload, ram_val(32'h200));
        tick(3);

        // Read and write requested together resolve to a write
        daddr = 32'h88; dstore = 32'h0BAD_F00D; dREN = 1'b1; dWEN = 1'b1;
        exp_dwrite(32'h88, 32'h0BAD_F00D);
        wait_done(4, 11, "t4b");
        dREN = 1'b0; dWEN = 1'b0;
        tick(3);

        // Stray ramready while idle is ignored
        stray = 1'b1;
        tick(4);
        stray = 1'b0;
        check("t5_ren", 32'(ramREN), 32'd0);
        check("t5_iwait", 32'(iwait), 32'd1);
        check("t5_dwait", 32'(dwait), 32'd1);
        tick(2);

        // Reset during IACC with ramready low: no completion pulse
        lat = 1000;
        iaddr = 32'h400; iREN = 1'b1;
        ram_q.push_back('{data: 1'b0, wen: 1'b0, addr: 32'h400, store: 32'h0});
        tick(2);
        check("t6_ren_pre", 32'(ramREN), 32'd1);
        RST = 1'b1; iREN = 1'b0;
        tick(1);
        check("t6_ren", 32'(ramREN), 32'd0);
        check("t6_iwait", 32'(iwait), 32'd1);
        RST = 1'b0; lat = 1;
        dload_exp = 32'h0;
        for (int k = 0; k < 4; k++) begin
            tick(1);
            check("t6_no_pulse", 32'(iwait), 32'd1);
        end
        check("t6_idone", 32'(i_done), 32'd4);

        // Three fetches and two loads back to back (counters cleared by reset)
        RST = 1'b1;
        tick(2);
        RST = 1'b0;
        blk_meas = 0;
        tick(1);
        iaddr = 32'h300; iREN = 1'b1;
        daddr = 32'h500; dREN = 1'b1;
        exp_dread(32'h500);
        exp_dread(32'h500);
        exp_fetch(32'h300);
        exp_fetch(32'h300);
        exp_fetch(32'h300);
        wait_done(4, 13, "t7_d");
        dREN = 1'b0;
        wait_done(7, 13, "t7_i");
        iREN = 1'b0;
        tick(3);
`ifdef MEMORY_ARBITER_PERF_EN
        check("t7_perf_igrants", perf_igrants, 32'd3);
        check("t7_perf_dgrants", perf_dgrants, 32'd2);
        check("t7_perf_iblocked", perf_iblocked, 32'(blk_meas));
`endif

        check("end_ramq_empty", 32'(ram_q.size()), 32'd0);
        check("end_iq_empty", 32'(iq.size()), 32'd0);
        check("end_dq_empty", 32'(dq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
